convolution_3x3_top: RTL and testbench
======================================

CONVOLUTION_3X3_TOP -- requirements
Module: convolution_3x3_top

Interface
REQ-001 The block SHALL have parameter ROW_SIZE, default 1280, giving pixels per image row and line-buffer depth.
REQ-002 The block SHALL have parameter PIXEL_SIZE, default 12, giving the input and output pixel width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port input_pixel, input, PIXEL_SIZE bits: unsigned grayscale sample, raster order.
REQ-006 The block SHALL have port valid_in, input, 1 bit: input_pixel is valid this cycle.
REQ-007 The block SHALL have port filter_type, input, 1 bit: 0 selects the Sobel Gx kernel, 1 selects the Sobel Gy kernel.
REQ-008 The block SHALL have port x_cont, input, 11 bits: column of the current input pixel, 0..ROW_SIZE-1.
REQ-009 The block SHALL have port y_cont, input, 11 bits: row of the current input pixel.
REQ-010 The block SHALL have port output_pixel, output, PIXEL_SIZE bits: filtered magnitude.
REQ-011 The block SHALL have port valid_out, output, 1 bit: output_pixel is valid this cycle.

Function
REQ-012 The block SHALL hold two row line buffers, each ROW_SIZE deep; on a valid_in cycle, the buffers and the 3x3 window SHALL advance by one pixel.
REQ-013 When valid_in=0, the line buffers, the window and the pipeline SHALL hold their contents.
REQ-014 The window SHALL hold rows y-2, y-1 and y, columns x-2..x; the output SHALL belong to centre pixel (x-1, y-1).
REQ-015 The Gx kernel SHALL be rows [-1 0 1], [-2 0 2], [-1 0 1]; the Gy kernel SHALL be rows [-1 -2 -1], [0 0 0], [1 2 1]. Left column and top row are the oldest samples.
REQ-016 filter_type SHALL be sampled together with the pixel on the same valid_in cycle.
REQ-017 The kernel sum SHALL be computed as a signed value, PIXEL_SIZE+4 bits wide, with no overflow.
REQ-018 output_pixel SHALL be min(|sum|, 255), zero-extended to PIXEL_SIZE bits.
REQ-019 Latency SHALL be exactly 2 clocks: if the pixel is sampled at edge N with valid_in=1, then valid_out=1 and the result appear after edge N+2.
REQ-020 The block SHALL produce exactly one output per valid input, and valid_out SHALL never assert without a corresponding input.
REQ-021 When x_cont<2 or y_cont<2 for the input pixel, the window is incomplete; the output for that pixel SHALL be 0 (see REQ-026).
REQ-022 Row wrap-around SHALL be driven only by x_cont/y_cont; the block SHALL keep no internal frame counters.

Reset
REQ-023 While rst=1 at a rising edge, the block SHALL clear valid_out to 0, output_pixel to 0, all window registers and all pipeline registers.
REQ-024 Reset SHALL NOT be required to clear the line-buffer storage, which MAY be inferred RAM or shift-tap macros.
REQ-025 Reset asserted mid-frame SHALL discard in-flight results; the first valid_out after release SHALL be 2 clocks after the first valid_in.

Configuration
REQ-026 With macro CONV_BORDER_ZERO_EN defined, REQ-021 forcing SHALL apply; without it, border outputs SHALL be the raw kernel result over whatever the window holds, and REQ-018 still applies.

Verification
REQ-027 All-zero 1280x4 image, filter_type=0 -> every output_pixel=0, and valid_out count = 5120.
REQ-028 Vertical step (columns<640 =0, columns>=640 =10), filter_type=0 -> interior outputs at centre columns 639 and 640 = 40, all other interior outputs = 0.
REQ-029 Same image, filter_type=1 -> all outputs 0. Horizontal step (rows<2 =0, rows>=2 =10), filter_type=1 -> outputs for centre rows 1 and 2 = 40.
REQ-030 Step of 0 to 4095 -> |sum| = 16380, so output_pixel = 255 (saturation); with CONV_BORDER_ZERO_EN, outputs for x_cont<2 or y_cont<2 = 0.
REQ-031 valid_in toggled 1-0-1 on alternate cycles -> results are identical to continuous streaming, and each valid_out occurs 2 clocks after its input.
REQ-032 rst pulsed for 1 cycle mid-row -> next cycle valid_out=0 and output_pixel=0, with no stale valid_out afterwards.

Source files
------------

// File: rtl/convolution_3x3_top.sv
// ---------------------------------------------------------------------------
// convolution_3x3_top
//
// Streaming 3x3 Sobel edge filter for a raster-ordered grayscale stream.
// Two line buffers addressed by the incoming column index supply the two
// rows above the current pixel. A 3x3 window slides one column per valid
// input. The selected kernel (Gx or Gy) is summed as a signed value, and the
// output is the saturated magnitude min(|sum|, 255).
//
// Pipeline (pixel sampled at edge N):
//   p0 (edge N)   : window shift, filter_type captured with the pixel
//   p1 (edge N+1) : signed kernel sum registered
//   p2 (edge N+2) : |sum| saturated to 255, valid_out asserted
//
// Optional feature macro: CONV_BORDER_ZERO_EN
//   When defined, outputs for pixels with x_cont < 2 or y_cont < 2 are forced
//   to 0. When undefined, those outputs are the raw kernel result over
//   whatever the window currently holds.
//
// Ports:
//   clk          - single rising-edge clock
//   rst          - synchronous active-high reset (control, window, pipeline)
//   input_pixel  - unsigned sample, PIXEL_SIZE bits
//   valid_in     - input_pixel valid this cycle
//   filter_type  - 0: Sobel Gx, 1: Sobel Gy (sampled with the pixel)
//   x_cont       - column of the current input pixel
//   y_cont       - row of the current input pixel
//   output_pixel - filtered magnitude, zero-extended to PIXEL_SIZE bits
//   valid_out    - output_pixel valid this cycle
// ---------------------------------------------------------------------------
module convolution_3x3_top #(
    parameter int ROW_SIZE   = 1280,
    parameter int PIXEL_SIZE = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIXEL_SIZE-1:0] input_pixel,
    input  logic                  valid_in,
    input  logic                  filter_type,
    input  logic [10:0]           x_cont,
    input  logic [10:0]           y_cont,
    output logic [PIXEL_SIZE-1:0] output_pixel,
    output logic                  valid_out
);

    localparam int SUM_W = PIXEL_SIZE + 4;
    localparam int AW    = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;

    // Zero-extend an unsigned pixel into the signed accumulator width.
    function automatic logic signed [SUM_W-1:0] ext(input logic [PIXEL_SIZE-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    // Magnitude of the kernel sum clipped to 255.
    function automatic logic [PIXEL_SIZE-1:0] abs_sat(input logic signed [SUM_W-1:0] s);
        logic [SUM_W-1:0] mag;
        mag = s[SUM_W-1] ? $unsigned(-s) : $unsigned(s);
        if (mag > SUM_W'(255))
            return PIXEL_SIZE'(255);
        return mag[PIXEL_SIZE-1:0];
    endfunction

    logic [AW-1:0]         addr;
    logic [PIXEL_SIZE-1:0] lb1_mem [ROW_SIZE];
    logic [PIXEL_SIZE-1:0] lb2_mem [ROW_SIZE];
    logic [PIXEL_SIZE-1:0] lb1_rd;
    logic [PIXEL_SIZE-1:0] lb2_rd;

    assign addr   = x_cont[AW-1:0];
    // Read-before-write: at column x, lb1 still holds row y-1 and lb2 row y-2.
    assign lb1_rd = lb1_mem[addr];
    assign lb2_rd = lb2_mem[addr];

    // Line buffers are plain storage; they are never reset.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb1_mem[addr] <= input_pixel;
            lb2_mem[addr] <= lb1_rd;
        end
    end

    // ---- stage p0: window shift ------------------------------------------
    // win_p0_q[row][col]: row 0 = y-2 (oldest), col 0 = x-2 (oldest).
    logic [PIXEL_SIZE-1:0] win_p0_q [3][3];
    logic                  vld_p0_q;
    logic                  ft_p0_q;
`ifdef CONV_BORDER_ZERO_EN
    logic                  border_p0_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_p0_q[r][c] <= '0;
            vld_p0_q <= 1'b0;
            ft_p0_q  <= 1'b0;
`ifdef CONV_BORDER_ZERO_EN
            border_p0_q <= 1'b0;
`endif
        end else begin
            vld_p0_q <= valid_in;
            if (valid_in) begin
                for (int r = 0; r < 3; r++) begin
                    win_p0_q[r][0] <= win_p0_q[r][1];
                    win_p0_q[r][1] <= win_p0_q[r][2];
                end
                win_p0_q[0][2] <= lb2_rd;
                win_p0_q[1][2] <= lb1_rd;
                win_p0_q[2][2] <= input_pixel;
                ft_p0_q        <= filter_type;
`ifdef CONV_BORDER_ZERO_EN
                border_p0_q    <= (x_cont < 11'd2) || (y_cont < 11'd2);
`endif
            end
        end
    end

    // ---- stage p1: signed kernel sum -------------------------------------
    logic signed [SUM_W-1:0] gx_d;
    logic signed [SUM_W-1:0] gy_d;
    logic signed [SUM_W-1:0] sum_d;

    always_comb begin
        gx_d  = (ext(win_p0_q[0][2]) + ext(win_p0_q[1][2]) + ext(win_p0_q[1][2]) + ext(win_p0_q[2][2]))
              - (ext(win_p0_q[0][0]) + ext(win_p0_q[1][0]) + ext(win_p0_q[1][0]) + ext(win_p0_q[2][0]));
        gy_d  = (ext(win_p0_q[2][0]) + ext(win_p0_q[2][1]) + ext(win_p0_q[2][1]) + ext(win_p0_q[2][2]))
              - (ext(win_p0_q[0][0]) + ext(win_p0_q[0][1]) + ext(win_p0_q[0][1]) + ext(win_p0_q[0][2]));
        sum_d = ft_p0_q ? gy_d : gx_d;
    end

    logic signed [SUM_W-1:0] sum_p1_q;
    logic                    vld_p1_q;
`ifdef CONV_BORDER_ZERO_EN
    logic                    border_p1_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1_q <= '0;
            vld_p1_q <= 1'b0;
`ifdef CONV_BORDER_ZERO_EN
            border_p1_q <= 1'b0;
`endif
        end else begin
            vld_p1_q <= vld_p0_q;
            if (vld_p0_q) begin
                sum_p1_q <= sum_d;
`ifdef CONV_BORDER_ZERO_EN
                border_p1_q <= border_p0_q;
`endif
            end
        end
    end

    // ---- stage p2: magnitude and saturation ------------------------------
    logic [PIXEL_SIZE-1:0] pix_d;
    logic [PIXEL_SIZE-1:0] pix_p2_q;
    logic                  vld_p2_q;

`ifdef CONV_BORDER_ZERO_EN
    assign pix_d = border_p1_q ? '0 : abs_sat(sum_p1_q);
`else
    assign pix_d = abs_sat(sum_p1_q);
    // Row/column position only matters for border forcing.
    logic unused_cont;
    assign unused_cont = ^{x_cont, y_cont};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_p2_q <= '0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q)
                pix_p2_q <= pix_d;
        end
    end

    assign output_pixel = pix_p2_q;
    assign valid_out    = vld_p2_q;

endmodule

// File: tb/tb_convolution_3x3_top.sv
module tb_convolution_3x3_top;

    localparam int ROW  = 1280;
    localparam int PW   = 12;
    localparam int MAXR = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] input_pixel;
    logic          valid_in;
    logic          filter_type;
    logic [10:0]   x_cont;
    logic [10:0]   y_cont;
    logic [PW-1:0] output_pixel;
    logic          valid_out;

    convolution_3x3_top #(.ROW_SIZE(ROW), .PIXEL_SIZE(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_pixel  (input_pixel),
        .valid_in     (valid_in),
        .filter_type  (filter_type),
        .x_cont       (x_cont),
        .y_cont       (y_cont),
        .output_pixel (output_pixel),
        .valid_out    (valid_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PW-1:0] img [MAXR][ROW];
    bit            ftv [MAXR][ROW];

    int exp_v[$];
    int exp_c[$];
    bit exp_k[$];
    int got_v[$];
    int got_c[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_print  = 0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            got_v.push_back(int'(output_pixel));
            got_c.push_back(cyc);
        end
    end

    // Reference: the window whose newest column is raster position p spans
    // raster positions p-2..p; each column carries its pixel and the pixels
    // directly above it in the two earlier rows. Value is min(|sum|,255).
    function automatic int model(input int y, input int x, input bit ft, output bit known);
        int p, q, cx, cy, s, w;
        known = 1'b1;
`ifdef CONV_BORDER_ZERO_EN
        if (x < 2 || y < 2) return 0;
`endif
        p = y * ROW + x;
        if (p - 2 < 2 * ROW) begin
            known = 1'b0;
            return 0;
        end
        s = 0;
        for (int k = 0; k < 3; k++) begin
            q  = p - 2 + k;
            cx = q % ROW;
            cy = q / ROW;
            for (int r = 0; r < 3; r++) begin
                if (ft) w = (r - 1) * ((k == 1) ? 2 : 1);
                else    w = (k - 1) * ((r == 1) ? 2 : 1);
                s += w * int'(img[cy - 2 + r][cx]);
            end
        end
        if (s < 0) s = -s;
        return (s > 255) ? 255 : s;
    endfunction

    // Drives one frame of img; gap: 0 none, 1 alternate idle, 2 random idle.
    // ftm: 0/1 fixed filter, 2 random per pixel.
    task automatic stream(input int rows, input int gap, input int ftm);
        int idle, v;
        bit k, ft;
        exp_v.delete(); exp_c.delete(); exp_k.delete();
        got_v.delete(); got_c.delete();
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < ROW; x++) begin
                idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
                repeat (idle) begin
                    @(negedge clk);
                    valid_in    = 1'b0;
                    input_pixel = PW'($urandom);
                    filter_type = 1'($urandom);
                end
                @(negedge clk);
                ft = (ftm == 2) ? 1'($urandom) : (ftm == 1);
                ftv[y][x]   = ft;
                valid_in    = 1'b1;
                input_pixel = img[y][x];
                filter_type = ft;
                x_cont      = 11'(x);
                y_cont      = 11'(y);
                v = model(y, x, ft, k);
                exp_v.push_back(v);
                exp_k.push_back(k);
                exp_c.push_back(cyc + 3);
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; input_pixel = '0; filter_type = 1'b0;
        x_cont = '0; y_cont = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL reset_valid_out got %b want 0", valid_out);
        else n_pass++;
        n_checks++;
        if (output_pixel !== '0) $display("FAIL reset_output_pixel got %0d want 0", output_pixel);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_image();
        for (int y = 0; y < 4; y++) for (int x = 0; x < ROW; x++) img[y][x] = '0;
        stream(4, 0, 0);
        n_checks++;
        if (got_v.size() != 5120) $display("FAIL zero_count got %0d want 5120", got_v.size());
        else n_pass++;
        for (int i = 0; i < got_v.size(); i++) begin
            n_checks++;
            if (got_v[i] != 0) begin
                if (n_print++ < 30) $display("FAIL zero_pixel idx %0d got %0d want 0", i, got_v[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_sobel_steps();
        int cy[4][2] = '{'{2, 2}, '{2, 3}, '{2, 3}, '{2, 2}};
        int cx[4][2] = '{'{640, 641}, '{640, 700}, '{100, 100}, '{640, 641}};
        int cv[4][2] = '{'{40, 40}, '{0, 0}, '{40, 40}, '{255, 255}};
        int rows, idx;
        for (int c = 0; c < 4; c++) begin
            rows = (c == 3) ? 3 : 4;
            for (int y = 0; y < rows; y++)
                for (int x = 0; x < ROW; x++)
                    case (c)
                        0, 1: img[y][x] = (x >= 640) ? PW'(10) : '0;
                        2:    img[y][x] = (y >= 2) ? PW'(10) : '0;
                        default: img[y][x] = (x >= 640) ? PW'(4095) : '0;
                    endcase
            stream(rows, 0, (c == 1 || c == 2) ? 1 : 0);
            n_checks++;
            if (got_v.size() != exp_v.size())
                $display("FAIL step%0d_count got %0d want %0d", c, got_v.size(), exp_v.size());
            else n_pass++;
            for (int i = 0; i < exp_v.size() && i < got_v.size(); i++) begin
                n_checks++;
                if (got_c[i] != exp_c[i]) begin
                    if (n_print++ < 30) $display("FAIL step%0d_latency idx %0d got cycle %0d want %0d", c, i, got_c[i], exp_c[i]);
                end else n_pass++;
                n_checks++;
                if (exp_k[i] ? (got_v[i] != exp_v[i]) : (got_v[i] > 255)) begin
                    if (n_print++ < 30) $display("FAIL step%0d_pixel idx %0d got %0d want %0d", c, i, got_v[i], exp_v[i]);
                end else n_pass++;
            end
            for (int j = 0; j < 2; j++) begin
                idx = cy[c][j] * ROW + cx[c][j];
                n_checks++;
                if (idx >= got_v.size() || got_v[idx] != cv[c][j])
                    $display("FAIL step%0d_point x%0d y%0d got %0d want %0d", c, cx[c][j], cy[c][j],
                             (idx < got_v.size()) ? got_v[idx] : -1, cv[c][j]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_valid_toggle();
        for (int y = 0; y < 3; y++) for (int x = 0; x < ROW; x++) img[y][x] = PW'($urandom);
        stream(3, 1, 2);
        n_checks++;
        if (got_v.size() != exp_v.size())
            $display("FAIL toggle_count got %0d want %0d", got_v.size(), exp_v.size());
        else n_pass++;
        for (int i = 0; i < exp_v.size() && i < got_v.size(); i++) begin
            n_checks++;
            if (got_c[i] != exp_c[i]) begin
                if (n_print++ < 30) $display("FAIL toggle_latency idx %0d got cycle %0d want %0d", i, got_c[i], exp_c[i]);
            end else n_pass++;
            n_checks++;
            if (exp_k[i] ? (got_v[i] != exp_v[i]) : (got_v[i] > 255)) begin
                if (n_print++ < 30) $display("FAIL toggle_pixel idx %0d got %0d want %0d", i, got_v[i], exp_v[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < ROW; x++)
                    img[y][x] = ($urandom_range(0, 3) == 0) ? PW'(4095) : PW'($urandom_range(0, 300));
            stream(3, (f == 0) ? 0 : 2, 2);
            n_checks++;
            if (got_v.size() != exp_v.size())
                $display("FAIL b2b%0d_count got %0d want %0d", f, got_v.size(), exp_v.size());
            else n_pass++;
            for (int i = 0; i < exp_v.size() && i < got_v.size(); i++) begin
                n_checks++;
                if (got_c[i] != exp_c[i]) begin
                    if (n_print++ < 30) $display("FAIL b2b%0d_latency idx %0d got cycle %0d want %0d", f, i, got_c[i], exp_c[i]);
                end else n_pass++;
                n_checks++;
                if (exp_k[i] ? (got_v[i] != exp_v[i]) : (got_v[i] > 255)) begin
                    if (n_print++ < 30) $display("FAIL b2b%0d_pixel idx %0d got %0d want %0d", f, i, got_v[i], exp_v[i]);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_midrow_reset();
        int n0;
        for (int x = 0; x < 20; x++) begin
            @(negedge clk);
            valid_in    = 1'b1;
            input_pixel = PW'($urandom);
            filter_type = 1'($urandom);
            x_cont      = 11'(600 + x);
            y_cont      = 11'd3;
        end
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL midreset_valid_out got %b want 0", valid_out);
        else n_pass++;
        n_checks++;
        if (output_pixel !== '0) $display("FAIL midreset_output_pixel got %0d want 0", output_pixel);
        else n_pass++;
        n0 = got_v.size();
        repeat (6) @(negedge clk);
        n_checks++;
        if (got_v.size() != n0) $display("FAIL midreset_stale got %0d outputs want 0", got_v.size() - n0);
        else n_pass++;
        for (int y = 0; y < 3; y++) for (int x = 0; x < ROW; x++) img[y][x] = PW'($urandom);
        stream(3, 0, 0);
        n_checks++;
        if (got_v.size() != exp_v.size())
            $display("FAIL midreset_count got %0d want %0d", got_v.size(), exp_v.size());
        else n_pass++;
        for (int i = 0; i < exp_v.size() && i < got_v.size(); i++) begin
            n_checks++;
            if (got_c[i] != exp_c[i]) begin
                if (n_print++ < 30) $display("FAIL midreset_latency idx %0d got cycle %0d want %0d", i, got_c[i], exp_c[i]);
            end else n_pass++;
            n_checks++;
            if (exp_k[i] ? (got_v[i] != exp_v[i]) : (got_v[i] > 255)) begin
                if (n_print++ < 30) $display("FAIL midreset_pixel idx %0d got %0d want %0d", i, got_v[i], exp_v[i]);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_image();
        test_sobel_steps();
        test_valid_toggle();
        test_back_to_back();
        test_midrow_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
